// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle for the hazard/stall unit: register IDs, stage write enables,
// memory/branch status in; bubble, pipeline enables, forwarding selects, status out.
interface hazard_stall_unit_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic [4:0]  ex_rd;
    logic [4:0]  mem_rd;
    logic [4:0]  wb_rd;
    logic        ex_rf_enable;
    logic        mem_rf_enable;
    logic        wb_rf_enable;
    logic        ex_load;
    logic        mem_wait;
    logic        branch_taken;
    logic        nop_signal;
    logic        pc_enable;
    logic        if_id_enable;
    logic        id_ex_enable;
    logic        if_id_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        mem_timeout;
    logic [15:0] stall_count;
    logic [15:0] bubble_count;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt,
        output ex_rd, mem_rd, wb_rd, ex_rf_enable, mem_rf_enable, wb_rf_enable,
        output ex_load, mem_wait, branch_taken,
        input  nop_signal, pc_enable, if_id_enable, id_ex_enable, if_id_flush,
        input  fwd_a, fwd_b, mem_timeout, stall_count, bubble_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  ex_rd, mem_rd, wb_rd, ex_rf_enable, mem_rf_enable, wb_rf_enable,
        input  ex_load, mem_wait, branch_taken,
        output nop_signal, pc_enable, if_id_enable, id_ex_enable, if_id_flush,
        output fwd_a, fwd_b, mem_timeout, stall_count, bubble_count
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use / memory-wait stall control with EX>MEM>WB operand forwarding.
// Define HAZARD_PERF_EN to build the saturating stall/bubble performance counters.
module hazard_stall_unit #(
    parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
    input  logic               clk,
    input  logic               reset,
    hazard_stall_unit_if.slave bus
);
    typedef enum logic [1:0] {RUN, MEM_HOLD, TIMEOUT} state_t;

    state_t     state_q, state_d, eff_state;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_timeout_q, mem_timeout_d;

    logic [4:0] src     [2];
    logic       uses    [2];
    logic       lu_hit  [2];
    logic [1:0] fwd_sel [2];
    logic       load_use;

    logic nop_c, pc_en_c, if_id_en_c, id_ex_en_c, flush_c;

    assign src[0]  = bus.id_rs;
    assign src[1]  = bus.id_rt;
    assign uses[0] = bus.id_uses_rs;
    assign uses[1] = bus.id_uses_rt;

    // A load in EX is never a forwarding source: its data only exists from MEM on.
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
        logic ex_hit, mem_hit, wb_hit;
        assign ex_hit  = bus.ex_rf_enable  & ~bus.ex_load & (bus.ex_rd  != 5'd0) & (bus.ex_rd  == src[gi]);
        assign mem_hit = bus.mem_rf_enable & (bus.mem_rd != 5'd0) & (bus.mem_rd == src[gi]);
        assign wb_hit  = bus.wb_rf_enable  & (bus.wb_rd  != 5'd0) & (bus.wb_rd  == src[gi]);
        assign fwd_sel[gi] = ex_hit  ? 2'b01 :
                             mem_hit ? 2'b10 :
                             wb_hit  ? 2'b11 : 2'b00;
        assign lu_hit[gi]  = uses[gi] & (src[gi] == bus.ex_rd);
    end

    assign load_use = bus.ex_load & bus.ex_rf_enable & (bus.ex_rd != 5'd0) & (lu_hit[0] | lu_hit[1]);

    // Reset forces the decode of outputs to RUN before the state flop is cleared.
    assign eff_state = reset ? RUN : state_q;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        nop_c         = 1'b0;
        pc_en_c       = 1'b0;
        if_id_en_c    = 1'b0;
        id_ex_en_c    = 1'b0;
        flush_c       = 1'b0;
        case (eff_state)
            RUN, MEM_HOLD: begin
                if (bus.mem_wait) begin
                    if (eff_state == RUN) begin
                        state_d    = MEM_HOLD;
                        wait_cnt_d = 8'd1;
                    end else if (wait_cnt_q == MEM_TIMEOUT) begin
                        state_d       = TIMEOUT;
                        mem_timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                    id_ex_en_c = 1'b1;
                    if (load_use) begin
                        nop_c = 1'b1;
                    end else begin
                        pc_en_c    = 1'b1;
                        if_id_en_c = 1'b1;
                        flush_c    = bus.branch_taken;
                    end
                end
            end
            TIMEOUT: mem_timeout_d = 1'b1;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign bus.nop_signal   = nop_c;
    assign bus.pc_enable    = pc_en_c;
    assign bus.if_id_enable = if_id_en_c;
    assign bus.id_ex_enable = id_ex_en_c;
    assign bus.if_id_flush  = flush_c;
    assign bus.fwd_a        = fwd_sel[0];
    assign bus.fwd_b        = fwd_sel[1];
    assign bus.mem_timeout  = mem_timeout_q;

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] bubble_count_q, bubble_count_d;

    always_comb begin
        stall_count_d  = stall_count_q;
        bubble_count_d = bubble_count_q;
        if (!pc_en_c && stall_count_q != 16'hFFFF)
            stall_count_d = stall_count_q + 16'd1;
        if (nop_c && bubble_count_q != 16'hFFFF)
            bubble_count_d = bubble_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q  <= 16'h0000;
            bubble_count_q <= 16'h0000;
        end else begin
            stall_count_q  <= stall_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign bus.stall_count  = stall_count_q;
    assign bus.bubble_count = bubble_count_q;
`else
    assign bus.stall_count  = 16'h0000;
    assign bus.bubble_count = 16'h0000;
`endif
endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 8'd255: maximum consecutive mem_wait cycles tolerated before timeout.
REQ-002 SHALL have ports clk (in, 1: single clock, rising edge) and reset (in, 1: synchronous, active-high).
REQ-003 SHALL have inputs id_rs and id_rt (5 each: ID source registers) and id_uses_rs and id_uses_rt (1 each: source actually read).
REQ-004 SHALL have inputs ex_rd, mem_rd and wb_rd (5 each) and ex_rf_enable, mem_rf_enable and wb_rf_enable (1 each: stage writes register file).
REQ-005 SHALL have inputs ex_load (1: EX instruction is a load), mem_wait (1: data memory not ready) and branch_taken (1: ID branch resolved taken).
REQ-006 SHALL have outputs nop_signal (1: drives control-unit mux bubble), pc_enable, if_id_enable, id_ex_enable and if_id_flush (1 each).
REQ-007 SHALL have outputs fwd_a and fwd_b (2 each; 00 regfile, 01 EX, 10 MEM, 11 WB) and mem_timeout (1, sticky).
REQ-008 SHALL have outputs stall_count and bubble_count (16 each: performance counters).

Function
REQ-009 SHALL implement FSM states RUN, MEM_HOLD and TIMEOUT.
REQ-010 Load-use hazard SHALL be detected when ex_load & ex_rf_enable & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)); combinational, same cycle.
REQ-011 RUN with mem_wait=0 and load-use: nop_signal=1, pc_enable=0, if_id_enable=0, id_ex_enable=1, if_id_flush=0; exactly one bubble per hazard.
REQ-012 RUN with mem_wait=0 and no hazard: nop_signal=0, all enables=1, if_id_flush=branch_taken.
REQ-013 RUN with mem_wait=1 SHALL take priority over load-use and branch: nop_signal=0, all enables=0, if_id_flush=0, next state MEM_HOLD, wait counter loaded with 1.
REQ-014 MEM_HOLD SHALL keep all enables=0 and nop_signal=0 while mem_wait=1, incrementing the 8-bit wait counter each cycle.
REQ-015 MEM_HOLD SHALL return to RUN on the cycle after mem_wait falls; outputs in that cycle follow RUN rules (REQ-011/012).
REQ-016 MEM_HOLD SHALL enter TIMEOUT when the wait counter equals MEM_TIMEOUT and mem_wait is still 1.
REQ-017 TIMEOUT SHALL assert mem_timeout=1, hold all enables=0 and nop_signal=0, and ignore all inputs until reset.
REQ-018 fwd_a/fwd_b SHALL be combinational with priority EX>MEM>WB; a match requires matching rd, the stage's rf_enable and rd!=0.
REQ-019 EX SHALL never be selected while ex_load=1 (REQ-010 covers that case); the next-priority match applies instead.
REQ-020 Register 0 SHALL never cause a hazard or forwarding (fwd=00).
REQ-021 Forwarding outputs SHALL be valid in all states; their values SHALL be independent of stall state.

Reset
REQ-022 On reset=1 at a clk edge: state=RUN, wait counter=0, mem_timeout=0, stall_count=0, bubble_count=0.
REQ-023 While reset=1 the combinational outputs SHALL follow RUN rules; reset SHALL abort MEM_HOLD or TIMEOUT within one edge.

Configuration
REQ-024 Macro HAZARD_PERF_EN defined: stall_count SHALL increment each cycle with pc_enable=0; bubble_count SHALL increment each cycle with nop_signal=1; both saturate at 16'hFFFF.
REQ-025 HAZARD_PERF_EN undefined: ports SHALL remain present, tied to 16'h0000, with no counter flops.

Verification
REQ-026 ex_load=1, ex_rd=5, ex_rf_enable=1, id_rs=5, id_uses_rs=1 -> same cycle nop_signal=1, pc_enable=0, if_id_enable=0; next cycle, with load in MEM (mem_rd=5), fwd_a=10, nop_signal=0.
REQ-027 EX, MEM and WB all write r7, id_rt=7, id_uses_rt=1, ex_load=0 -> fwd_b=01; drop ex_rf_enable -> fwd_b=10; ex_rd=0 with id_rt=0 -> fwd_b=00.
REQ-028 mem_wait=1 for 3 cycles, with a load-use hazard and branch_taken=1 present -> enables=0 for 3 cycles, nop_signal=0, if_id_flush=0; RUN resumes; HAZARD_PERF_EN build: stall_count=3.
REQ-029 MEM_TIMEOUT=4, mem_wait held 1 -> mem_timeout=1 after 4th hold cycle; mem_timeout stays 1 after mem_wait=0; reset -> mem_timeout=0, state RUN.
REQ-030 branch_taken=1 in RUN with no hazard -> if_id_flush=1, pc_enable=1; same cycle with load-use hazard -> if_id_flush=0.
REQ-031 Reset asserted mid-MEM_HOLD (mem_wait=1) -> next edge state RUN, counters 0; then enables=0 only via fresh RUN->MEM_HOLD entry.
